rotating_square: RTL and testbench

//  Animates a single "square" circling the 4-digit 7-segment display: the upper square
//   (segments a,b,f,g) runs across the top of the digits and the lower square
//   (segments c,d,e,g) runs across the bottom.
//  An enable pauses the animation; a direction input selects clockwise or counter-clockwise.

---
 rtl/rotating_square.sv | 84 ++++++++
 tb/tb_rotating_square.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rotating_square.sv
// rotating_square: one square circling the 4-digit 7-segment display.
// The upper square (a,b,f,g) moves along the top of the digits and the lower
// square (c,d,e,g) moves along the bottom. The square takes one step every
// 2**N enabled clocks. Only one digit is lit at a time, so no multiplexing.

// Free-running prescaler: N-bit up counter that pulses tick at all-ones.
module rotating_square_prescaler #(
    parameter int N = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [N-1:0] q;

    // Count enabled clocks; hold while paused, clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= q + N'(1);
        end
    end

    // Tick is qualified by en so a frozen all-ones count never steps.
    assign tick = en & (q == {N{1'b1}});

endmodule

module rotating_square #(
    parameter int N = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cw,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam logic [7:0] SSEG_UPPER = 8'b1001_1100;
    localparam logic [7:0] SSEG_LOWER = 8'b1010_0011;

    logic       tick;
    logic [2:0] pos;
    logic [1:0] digit;

    rotating_square_prescaler #(
        .N(N)
    ) counter (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    // Position around the ring: +1 clockwise, -1 counter-clockwise, mod 8.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos <= 3'd0;
        end else if (tick) begin
            pos <= cw ? pos + 3'd1 : pos - 3'd1;
        end
    end

    // Decode: positions 0..3 run left->right on top (digit 3..0),
    // positions 4..7 run right->left on the bottom (digit 0..3).
    always_comb begin
        digit = 2'd0;
        an    = 4'b1111;
        sseg  = SSEG_UPPER;
        if (pos[2]) begin
            digit = pos[1:0];
            sseg  = SSEG_LOWER;
        end else begin
            digit = 2'd3 - pos[1:0];
            sseg  = SSEG_UPPER;
        end
        an = ~(4'b0001 << digit);
    end

endmodule

// File: tb/tb_rotating_square.sv
// Self-checking bench for rotating_square with a 3-bit prescaler (step every 8 clocks).
module tb_rotating_square;

    logic       clk;
    logic       rst;
    logic       en;
    logic       cw;
    logic [3:0] an;
    logic [7:0] sseg;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] UP = 8'b1001_1100;
    localparam logic [7:0] LO = 8'b1010_0011;

    rotating_square #(.N(3)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .cw  (cw),
        .an  (an),
        .sseg(sseg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counts enabled clocks since reset; every 8th one
    // moves the square one place around the perimeter.
    int m_cnt = 0;
    int m_pos = 0;
    int ring_digit[8] = '{3, 2, 1, 0, 0, 1, 2, 3};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0;
            m_pos = 0;
        end else if (en) begin
            m_cnt = m_cnt + 1;
            if (m_cnt % 8 == 0) m_pos = (m_pos + (cw ? 1 : 7)) % 8;
        end
    end

    function automatic logic [3:0] exp_an(input int p);
        logic [3:0] v;
        v = 4'b1111;
        v[ring_digit[p]] = 1'b0;
        return v;
    endfunction

    function automatic logic [7:0] exp_sseg(input int p);
        return (p < 4) ? UP : LO;
    endfunction

    // Spec tables for a full clockwise lap, index = steps taken.
    logic [3:0] sweep_an[9]   = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1110,
                                  4'b1101, 4'b1011, 4'b0111, 4'b0111};
    logic [7:0] sweep_sseg[9] = '{UP, UP, UP, UP, LO, LO, LO, LO, UP};
    logic [3:0] ccw_an[4]     = '{4'b1011, 4'b0111, 4'b0111, 4'b1011};
    logic [7:0] ccw_sseg[4]   = '{UP, UP, LO, LO};

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; cw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'b0111 || sseg !== UP) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got an=%b sseg=%b want an=0111 sseg=%b", i, an, sseg, UP);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'b0111 || sseg !== UP) begin
                errors++;
                $display("FAIL reset_release_idle cyc %0d got an=%b sseg=%b want an=0111 sseg=%b", i, an, sseg, UP);
            end
        end
    endtask

    task automatic test_cw_sweep();
        en = 1'b1; cw = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                checks++;
                if (an !== sweep_an[s-1] || sseg !== sweep_sseg[s-1]) begin
                    errors++;
                    $display("FAIL sweep_early step %0d clk %0d got an=%b sseg=%b want an=%b sseg=%b",
                             s, c, an, sseg, sweep_an[s-1], sweep_sseg[s-1]);
                end
            end
            @(negedge clk);
            checks++;
            if (an !== sweep_an[s] || sseg !== sweep_sseg[s]) begin
                errors++;
                $display("FAIL sweep_step %0d got an=%b sseg=%b want an=%b sseg=%b",
                         s, an, sseg, sweep_an[s], sweep_sseg[s]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_ccw();
        en = 1'b1; cw = 1'b1;
        repeat (16) @(negedge clk);
        checks++;
        if (an !== 4'b1101 || sseg !== UP) begin
            errors++;
            $display("FAIL ccw_start got an=%b sseg=%b want an=1101 sseg=%b", an, sseg, UP);
        end
        cw = 1'b0;
        for (int s = 0; s < 4; s++) begin
            repeat (8) @(negedge clk);
            checks++;
            if (an !== ccw_an[s] || sseg !== ccw_sseg[s]) begin
                errors++;
                $display("FAIL ccw_step %0d got an=%b sseg=%b want an=%b sseg=%b",
                         s, an, sseg, ccw_an[s], ccw_sseg[s]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_pause();
        for (int r = 0; r < 3; r++) begin
            int k;
            int n;
            int rem;
            logic [11:0] held;
            k  = int'($urandom_range(1, 7));
            cw = 1'($urandom);
            en = 1'b1;
            repeat (k) @(negedge clk);
            en   = 1'b0;
            held = {an, sseg};
            rem  = 8 - (m_cnt % 8);
            repeat (10) begin
                @(negedge clk);
                checks++;
                if ({an, sseg} !== held) begin
                    errors++;
                    $display("FAIL pause_static round %0d got %b want %b", r, {an, sseg}, held);
                end
            end
            en = 1'b1;
            n  = 0;
            while ({an, sseg} === held && n < 20) begin
                @(negedge clk);
                n++;
            end
            en = 1'b0;
            checks++;
            if (n != rem) begin
                errors++;
                $display("FAIL pause_resume round %0d (k=%0d) step after %0d clks want %0d", r, k, n, rem);
            end
            checks++;
            if (an !== exp_an(m_pos) || sseg !== exp_sseg(m_pos)) begin
                errors++;
                $display("FAIL pause_model round %0d got an=%b sseg=%b want an=%b sseg=%b",
                         r, an, sseg, exp_an(m_pos), exp_sseg(m_pos));
            end
        end
    endtask

    task automatic test_cw_at_tick();
        for (int r = 0; r < 2; r++) begin
            int p;
            int want;
            logic newcw;
            newcw = (r == 0) ? 1'b0 : 1'b1;
            en = 1'b1; cw = ~newcw;
            while (m_cnt % 8 != 7) @(negedge clk);
            p  = m_pos;
            cw = newcw;
            @(negedge clk);
            want = newcw ? (p + 1) % 8 : (p + 7) % 8;
            checks++;
            if (an !== exp_an(want) || sseg !== exp_sseg(want)) begin
                errors++;
                $display("FAIL cw_at_tick cw=%0b from pos %0d got an=%b sseg=%b want an=%b sseg=%b",
                         newcw, p, an, sseg, exp_an(want), exp_sseg(want));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an(m_pos) || sseg !== exp_sseg(m_pos)) begin
                errors++;
                $display("FAIL random cyc %0d got an=%b sseg=%b want an=%b sseg=%b",
                         i, an, sseg, exp_an(m_pos), exp_sseg(m_pos));
            end
            en = ($urandom_range(0, 3) != 0);
            cw = ($urandom_range(0, 4) != 0);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; en = 1'b1; cw = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (an !== 4'b1101 || sseg !== LO) begin
            errors++;
            $display("FAIL reset_mid_pos5 got an=%b sseg=%b want an=1101 sseg=%b", an, sseg, LO);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (an !== 4'b0111 || sseg !== UP) begin
            errors++;
            $display("FAIL reset_mid_async got an=%b sseg=%b want an=0111 sseg=%b", an, sseg, UP);
        end
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (an === 4'b0111 && sseg === UP && n < 20) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        checks++;
        if (n != 8 || an !== 4'b1011 || sseg !== UP) begin
            errors++;
            $display("FAIL reset_mid_restart step after %0d clks an=%b want 8 clks an=1011", n, an);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; cw = 1'b1;
        test_reset();
        test_cw_sweep();
        test_ccw();
        test_pause();
        test_cw_at_tick();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
